// File: rtl/elbeth_if_id_skid_buffer.sv
// -----------------------------------------------------------------------------
// elbeth_if_id_skid_buffer
//
// Two-entry IF->ID pipeline register with a skid slot. The output register
// drives the ID stage directly; the skid register catches the one beat that
// can arrive while the output register is held. if_ready is registered, so
// there is no combinational path from id_ready / ctrl_stall back to IF.
//
// Parameters
//   INSTR_W  instruction width
//   PC_W     program-counter width
//   EXC_W    exception-source code width
//   NOP_VAL  bubble instruction presented while id_valid is low
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous reset, active low
//   if_valid/if_ready   upstream handshake
//   if_instruction, if_pc, if_except, if_except_src   upstream payload
//   id_valid/id_ready   downstream handshake
//   id_instruction, id_pc, id_except, id_except_src   downstream payload
//   ctrl_stall          hold downstream (blocks drain only)
//   ctrl_flush          discard every held beat and the same-cycle input beat
//   occupancy           number of valid entries, 0..2
// -----------------------------------------------------------------------------
module elbeth_if_id_skid_buffer #(
    parameter int unsigned          INSTR_W = 32,
    parameter int unsigned          PC_W    = 32,
    parameter int unsigned          EXC_W   = 4,
    parameter logic [INSTR_W-1:0]   NOP_VAL = INSTR_W'(32'h0000_0013)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               if_valid,
    output logic               if_ready,
    input  logic [INSTR_W-1:0] if_instruction,
    input  logic [PC_W-1:0]    if_pc,
    input  logic               if_except,
    input  logic [EXC_W-1:0]   if_except_src,

    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_except,
    output logic [EXC_W-1:0]   id_except_src,

    input  logic               ctrl_stall,
    input  logic               ctrl_flush,
    output logic [1:0]         occupancy
);

    localparam int unsigned BEAT_W = INSTR_W + PC_W + 1 + EXC_W;

    // State encoding equals the number of valid entries, so occupancy and
    // both valid bits fall straight out of the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_ONE   = 2'd1,   // output register valid, skid empty
        ST_TWO   = 2'd2    // output and skid both valid
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   out_q,   out_d;
    logic [BEAT_W-1:0]   skid_q,  skid_d;
    logic                if_ready_q, if_ready_d;

    logic [BEAT_W-1:0]   in_beat;
    logic [BEAT_W-1:0]   bubble;
    logic                accept;
    logic                drain;

    assign in_beat = {if_instruction, if_pc, if_except, if_except_src};

    // Idle value of the output register: NOP with zero pc / exception fields.
    assign bubble  = {NOP_VAL, {(BEAT_W - INSTR_W){1'b0}}};

    assign accept  = if_valid & if_ready_q & ~ctrl_flush;
    assign drain   = (state_q != ST_EMPTY) & id_ready & ~ctrl_stall & ~ctrl_flush;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        if (ctrl_flush) begin
            state_d = ST_EMPTY;
            out_d   = bubble;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = in_beat;
                        state_d = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (drain && accept) begin
                        out_d   = in_beat;          // full throughput
                    end else if (drain) begin
                        out_d   = bubble;
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_beat;          // output held, catch in skid
                        state_d = ST_TWO;
                    end
                end

                ST_TWO: begin
                    // if_ready_q is low here, so no accept can coincide.
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                    out_d   = bubble;
                end
            endcase
        end

        // Registered ready: low exactly while the skid slot will be occupied.
        if_ready_d = (state_d != ST_TWO);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= bubble;
            skid_q     <= '0;
            if_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            if_ready_q <= if_ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign if_ready  = if_ready_q;
    assign id_valid  = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign {id_instruction, id_pc, id_except, id_except_src} = out_q;

endmodule
